// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: instruction-memory read port, decode handoff and execute redirect.
// master = fetch_sequencer, slave = memory/decode/execute side.
interface fetch_sequencer_if #(
  parameter int IMEM_ADDR_W = 8
);
  logic                   imem_req;
  logic [IMEM_ADDR_W-1:0] imem_addr;
  logic [31:0]            imem_rdata;
  logic                   inst_valid;
  logic                   inst_ready;
  logic [31:0]            inst;
  logic [31:0]            inst_pc;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_rdata, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_rdata, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_sequencer.sv
// RV32 instruction fetch: owns PC, one word read in flight, faults on bad PC (FETCH_PERF_CNT_EN adds counters).
// Latency: request in cycle 0, inst_valid in cycle 2; 3 cycles/instruction with decode always ready.
// Backpressure: held instruction waits on inst_ready; halt only blocks new issue.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.master fif,
  input  logic              halt,
  output logic              fetch_fault,
  output logic [31:0]       fault_pc,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_FAULT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        inst_valid_q;
  logic        pc_bad;
  logic        req;
  logic        accept;

  // Bad PC: misaligned, or any set bit above the addressable word range.
  assign pc_bad = (pc[1:0] != 2'b00) || ((pc >> (IMEM_ADDR_W + 2)) != 32'd0);
  assign req    = !reset && (state == S_FETCH) && !pc_bad && !halt;
  assign accept = inst_valid_q && fif.inst_ready;

  assign fif.imem_req   = req;
  assign fif.imem_addr  = req ? pc[IMEM_ADDR_W+1:2] : '0;
  assign fif.inst_valid = inst_valid_q;
  assign fif.inst       = inst_q;
  assign fif.inst_pc    = inst_pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_FETCH;
      pc           <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      fetch_fault  <= 1'b0;
      fault_pc     <= '0;
    end else if (fif.redirect_valid) begin
      // Redirect wins everywhere; an in-flight read is dropped by leaving WAIT.
      pc           <= fif.redirect_pc;
      inst_valid_q <= 1'b0;
      fetch_fault  <= 1'b0;
      state        <= S_FETCH;
    end else begin
      case (state)
        S_FETCH: begin
          if (pc_bad) begin
            fetch_fault <= 1'b1;
            fault_pc    <= pc;
            state       <= S_FAULT;
          end else if (!halt) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          inst_q       <= fif.imem_rdata;
          inst_pc_q    <= pc;
          inst_valid_q <= 1'b1;
          state        <= S_HOLD;
        end
        S_HOLD: begin
          if (accept) begin
            inst_valid_q <= 1'b0;
            pc           <= pc + 32'd4;
            state        <= S_FETCH;
          end
        end
        S_FAULT: begin
          state <= S_FAULT;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (accept) perf_fetched <= perf_fetched + 32'd1;
      if (inst_valid_q && !fif.inst_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`else
  assign perf_fetched = '0;
  assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed latency/redirect/fault cases, then random redirects, stalls and halts
// scored against a transaction-level queue of expected accepted instructions and faults.
module tb_fetch_sequencer;
  localparam int          IMEM_ADDR_W = 8;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] DEPTH_BYTES = 32'(4) << IMEM_ADDR_W;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    bit          is_fault;
    logic [31:0] pc;
    logic [31:0] dat;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        halt;
  logic        fetch_fault;
  logic [31:0] fault_pc;
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;

  fetch_sequencer_if #(.IMEM_ADDR_W(IMEM_ADDR_W)) fif();

  fetch_sequencer #(.RESET_PC(RESET_PC), .IMEM_ADDR_W(IMEM_ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .fif          (fif),
    .halt         (halt),
    .fetch_fault  (fetch_fault),
    .fault_pc     (fault_pc),
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<IMEM_ADDR_W)-1];
  exp_t        q[$];
  int          nchk = 0;
  int          npass = 0;
  int          cnt_acc = 0;
  int          cnt_stall = 0;
  int          total_acc = 0;
  logic        prev_fault = 1'b0;

  // Synchronous-read memory; idle cycles return noise so stray captures show up.
  always @(posedge clk) begin
    if (fif.imem_req) fif.imem_rdata <= mem[fif.imem_addr];
    else              fif.imem_rdata <= $urandom();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act === req) npass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Expected program order from a start PC: sequential words until the first bad address.
  task automatic restart(input logic [31:0] start);
    logic [31:0] p;
    exp_t        e;
    q.delete();
    p = start;
    for (int k = 0; k < 300; k++) begin
      e.pc = p;
      if (p[1:0] != 2'b00 || p >= DEPTH_BYTES) begin
        e.is_fault = 1'b1;
        e.dat      = '0;
        q.push_back(e);
        break;
      end
      e.is_fault = 1'b0;
      e.dat      = mem[p / 4];
      q.push_back(e);
      p = p + 32'd4;
    end
  endtask

  // Monitor: pops one expectation per accepted instruction or per new fault.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      cnt_acc    = 0;
      cnt_stall  = 0;
      prev_fault = 1'b0;
    end else begin
      if (fif.inst_valid && fif.inst_ready) begin
        cnt_acc++;
        total_acc++;
        if (q.size() == 0) begin
          nchk++;
          $display("FAIL sb_accept_underflow: got inst_pc %h, required no accept", fif.inst_pc);
        end else begin
          e = q.pop_front();
          chk("sb_accept_kind", 32'(e.is_fault), 32'd0);
          chk("sb_inst_pc", fif.inst_pc, e.pc);
          chk("sb_inst", fif.inst, e.dat);
        end
      end
      if (fif.inst_valid && !fif.inst_ready) cnt_stall++;
      if (fetch_fault && !prev_fault) begin
        if (q.size() == 0) begin
          nchk++;
          $display("FAIL sb_fault_underflow: got fault_pc %h, required no fault", fault_pc);
        end else begin
          e = q.pop_front();
          chk("sb_fault_kind", 32'(e.is_fault), 32'd1);
          chk("sb_fault_pc", fault_pc, e.pc);
        end
      end
      prev_fault = fetch_fault;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!fif.inst_valid && n < 20) begin
      next_cycle();
      sample();
      n++;
    end
    chk(name, 32'(fif.inst_valid), 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    next_cycle();
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = tgt;
    sample();
    next_cycle();
    fif.redirect_valid = 1'b0;
    restart(tgt);
    sample();
  endtask

  initial begin
    logic [31:0] tgt;
    int          len;
    reset = 1'b1;
    halt  = 1'b0;
    fif.inst_ready     = 1'b0;
    fif.redirect_valid = 1'b0;
    fif.redirect_pc    = '0;
    for (int i = 0; i < (1 << IMEM_ADDR_W); i++) mem[i] = $urandom();
    mem[0] = 32'h002081B3;
    mem[1] = 32'h00308193;

    repeat (2) begin next_cycle(); sample(); end
    chk("rst_imem_req", 32'(fif.imem_req), 32'd0);
    chk("rst_imem_addr", 32'(fif.imem_addr), 32'd0);
    chk("rst_inst_valid", 32'(fif.inst_valid), 32'd0);
    chk("rst_inst", fif.inst, 32'd0);
    chk("rst_inst_pc", fif.inst_pc, 32'd0);
    chk("rst_fetch_fault", 32'(fetch_fault), 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);
    chk("rst_perf_fetched", perf_fetched, 32'd0);
    chk("rst_perf_stall", perf_stall, 32'd0);

    // Reset release latency: request in cycle 0, instruction in cycle 2, next one in cycle 5.
    next_cycle(); reset = 1'b0; fif.inst_ready = 1'b1; restart(RESET_PC); sample();
    chk("c0_imem_req", 32'(fif.imem_req), 32'd1);
    chk("c0_imem_addr", 32'(fif.imem_addr), 32'd0);
    next_cycle(); sample();
    chk("c1_imem_req", 32'(fif.imem_req), 32'd0);
    chk("c1_inst_valid", 32'(fif.inst_valid), 32'd0);
    next_cycle(); sample();
    chk("c2_inst_valid", 32'(fif.inst_valid), 32'd1);
    chk("c2_inst", fif.inst, 32'h002081B3);
    chk("c2_inst_pc", fif.inst_pc, 32'd0);
    next_cycle(); sample();
    chk("c3_imem_addr", 32'(fif.imem_addr), 32'd1);
    next_cycle(); fif.inst_ready = 1'b0; sample();
    next_cycle(); sample();
    chk("c5_inst_valid", 32'(fif.inst_valid), 32'd1);
    chk("c5_inst_pc", fif.inst_pc, 32'd4);

    // Decode stalls four cycles: held data stable, no new request.
    for (int i = 0; i < 3; i++) begin
      next_cycle(); sample();
      chk("stall_inst_pc", fif.inst_pc, 32'd4);
      chk("stall_inst", fif.inst, 32'h00308193);
      chk("stall_imem_req", 32'(fif.imem_req), 32'd0);
    end
    next_cycle(); fif.inst_ready = 1'b1; sample();
    chk("stall_perf_stall", perf_stall, PERF ? 32'd4 : 32'd0);
    chk("stall_perf_fetched", perf_fetched, PERF ? 32'd1 : 32'd0);

    // Redirect during the read of pc=8 drops that word.
    next_cycle(); sample();
    chk("pc8_imem_addr", 32'(fif.imem_addr), 32'd2);
    next_cycle(); fif.redirect_valid = 1'b1; fif.redirect_pc = 32'h20; sample();
    chk("pc8_wait_req", 32'(fif.imem_req), 32'd0);
    next_cycle(); fif.redirect_valid = 1'b0; restart(32'h20); sample();
    chk("redir_inst_valid", 32'(fif.inst_valid), 32'd0);
    chk("redir_imem_addr", 32'(fif.imem_addr), 32'd8);
    next_cycle(); sample();
    // Redirect to a misaligned target in the same cycle the held word is accepted.
    next_cycle(); fif.redirect_valid = 1'b1; fif.redirect_pc = 32'h22; sample();
    chk("redir_inst_pc", fif.inst_pc, 32'h20);
    chk("redir_inst", fif.inst, mem[8]);
    next_cycle(); fif.redirect_valid = 1'b0; restart(32'h22); sample();
    chk("mis_no_req", 32'(fif.imem_req), 32'd0);
    next_cycle(); sample();
    chk("mis_fault", 32'(fetch_fault), 32'd1);
    chk("mis_fault_pc", fault_pc, 32'h22);
    for (int i = 0; i < 2; i++) begin
      next_cycle(); sample();
      chk("fault_idle_req", 32'(fif.imem_req), 32'd0);
    end
    do_redirect(32'h10);
    chk("unfault_flag", 32'(fetch_fault), 32'd0);
    chk("unfault_addr", 32'(fif.imem_addr), 32'd4);
    wait_valid("unfault_valid");
    chk("unfault_inst_pc", fif.inst_pc, 32'h10);

    // Memory-depth boundary.
    do_redirect(32'h400);
    chk("oor_no_req", 32'(fif.imem_req), 32'd0);
    next_cycle(); sample();
    chk("oor_fault_pc", fault_pc, 32'h400);
    do_redirect(32'h3FC);
    chk("last_imem_addr", 32'(fif.imem_addr), 32'd255);
    wait_valid("last_valid");
    chk("last_inst_pc", fif.inst_pc, 32'h3FC);
    next_cycle(); sample();
    chk("end_no_req", 32'(fif.imem_req), 32'd0);
    next_cycle(); sample();
    chk("end_fault", 32'(fetch_fault), 32'd1);
    chk("end_fault_pc", fault_pc, 32'h400);

    // Halt from reset, then reset while holding an instruction.
    next_cycle(); reset = 1'b1; halt = 1'b1; fif.inst_ready = 1'b0; sample();
    next_cycle(); reset = 1'b0; restart(RESET_PC); sample();
    chk("halt_req0", 32'(fif.imem_req), 32'd0);
    for (int i = 0; i < 2; i++) begin
      next_cycle(); sample();
      chk("halt_req", 32'(fif.imem_req), 32'd0);
    end
    next_cycle(); halt = 1'b0; sample();
    chk("unhalt_req", 32'(fif.imem_req), 32'd1);
    chk("unhalt_addr", 32'(fif.imem_addr), RESET_PC / 4);
    wait_valid("unhalt_valid");
    next_cycle(); halt = 1'b1; sample();
    chk("halt_keeps_inst", 32'(fif.inst_valid), 32'd1);
    next_cycle(); reset = 1'b1; sample();
    next_cycle(); reset = 1'b0; halt = 1'b0; restart(RESET_PC); sample();
    chk("hold_reset_valid", 32'(fif.inst_valid), 32'd0);
    chk("hold_reset_stall", perf_stall, 32'd0);

    // Random episodes: redirect (or reset), then random decode readiness and halts.
    next_cycle();
    for (int ep = 0; ep < 60; ep++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: tgt = 32'($urandom_range(0, 255)) * 4;
        5:             tgt = 32'h3F0 + 32'($urandom_range(0, 3)) * 4;
        6:             tgt = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
        7:             tgt = DEPTH_BYTES + 32'($urandom_range(0, 255)) * 4;
        8:             tgt = 32'hFFFF_FFFC;
        default:       tgt = RESET_PC;
      endcase
      if ($urandom_range(0, 7) == 0) begin
        reset = 1'b1; fif.inst_ready = 1'b0;
        sample(); next_cycle();
        reset = 1'b0; restart(RESET_PC);
      end else begin
        fif.redirect_valid = 1'b1; fif.redirect_pc = tgt;
        fif.inst_ready = ($urandom_range(0, 99) < 70);
        sample(); next_cycle();
        fif.redirect_valid = 1'b0; restart(tgt);
      end
      len = $urandom_range(8, 60);
      for (int c = 0; c < len; c++) begin
        fif.inst_ready = ($urandom_range(0, 99) < 70);
        halt           = ($urandom_range(0, 99) < 15);
        sample(); next_cycle();
      end
      chk("ep_perf_fetched", perf_fetched, PERF ? 32'(cnt_acc) : 32'd0);
      chk("ep_perf_stall", perf_stall, PERF ? 32'(cnt_stall) : 32'd0);
    end
    chk("enough_accepts", 32'(total_acc >= 40), 32'd1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller for the non-pipelined RV32 core. It owns the PC, sequences word reads from the synchronous-read instruction memory, and presents one instruction at a time to decode through a valid/ready handshake. Branch/JAL/JALR redirects from execute steer it. Misaligned or out-of-range fetch addresses are flagged as a fault.

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset
IMEM_ADDR_W, 8, instruction-memory word-index width (depth = 2**IMEM_ADDR_W words)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  reset, synchronous, active-high
imem_req  out  1  read strobe to instruction memory
imem_addr  out  IMEM_ADDR_W  word index = pc[IMEM_ADDR_W+1:2]
imem_rdata  in  32  read data, valid exactly one cycle after imem_req
inst_valid  out  1  inst/inst_pc hold a fetched instruction
inst_ready  in  1  decode accepts the instruction this cycle
inst  out  32  fetched instruction word
inst_pc  out  32  byte address of inst
redirect_valid  in  1  execute requests a PC change (taken branch, JAL, JALR)
redirect_pc  in  32  target byte address
halt  in  1  suppress issue of new fetches
fetch_fault  out  1  sticky: PC misaligned or beyond memory depth
fault_pc  out  32  PC that caused the fault
perf_fetched  out  32  accepted-instruction count (see Optional Feature)
perf_stall  out  32  decode back-pressure cycle count (see Optional Feature)

Behaviour:
- Reset values: pc=RESET_PC, state=FETCH, imem_req=0, imem_addr=0, inst_valid=0, inst=0, inst_pc=0, fetch_fault=0, fault_pc=0, perf counters=0.
- imem_req and imem_addr are combinational from state/pc. Everything else is registered.
- FETCH:
  - If pc[1:0]!=0 or pc[31:IMEM_ADDR_W+2]!=0: fetch_fault<=1, fault_pc<=pc, go FAULT. No request is issued.
  - Else if halt=1: stay in FETCH, imem_req=0.
  - Else: imem_req=1, imem_addr=pc word index, go WAIT.
- WAIT: imem_req=0. At the clock edge, inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, go HOLD.
- HOLD: inst_valid=1, inst and inst_pc stable. On inst_valid&&inst_ready: inst_valid<=0, pc<=pc+4 (mod 2**32), go FETCH.
- FAULT: idle with imem_req=0 and fetch_fault=1. Only reset or redirect exits.
- Latency: reset released at cycle 0 gives the request in cycle 0 and inst_valid=1 in cycle 2. Steady state is 3 cycles per instruction when inst_ready is tied high.
- Redirect has the highest priority in every state. On redirect_valid=1:
  - pc<=redirect_pc, inst_valid<=0, fetch_fault<=0, go FETCH.
  - A read in flight (WAIT) is discarded; its rdata is never captured.
  - In HOLD, redirect together with inst_ready: the handshake is treated as consumed, but pc takes redirect_pc, not pc+4.
  - Alignment and range are checked in the following FETCH cycle, not on the redirect itself.
- halt does not cancel a read in flight or drop a held instruction. It only blocks new issue in FETCH.
- Reset asserted mid-operation (any state): all registers return to reset values on that edge. The returning rdata is ignored.
- pc wrap: pc+4 from 32'hFFFF_FFFC gives 0. Any pc beyond memory depth faults before issue.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined:
  - perf_fetched increments on every inst_valid&&inst_ready.
  - perf_stall increments on every cycle with inst_valid&&!inst_ready.
  - Both are 32-bit, wrap silently, clear on reset, and are not affected by redirect.
- Undefined: perf_fetched and perf_stall are tied to 0 and no counter flops are instantiated. Ports are present in both builds.

Test Plan:
- Reset release, imem word0=32'h002081B3, word1=32'h00308193, inst_ready=1 -> imem_addr 0 in cycle 0; inst=32'h002081B3 with inst_pc=0 in cycle 2; inst_pc=4 in cycle 5.
- inst_ready held 0 for 4 cycles in HOLD -> inst and inst_pc stable, no new imem_req, perf_stall=4 with FETCH_PERF_CNT_EN.
- redirect_valid with redirect_pc=32'h20 during WAIT of pc=8 -> old rdata dropped, next imem_addr=8, next inst_pc=32'h20.
- redirect_pc=32'h22 -> fetch_fault=1, fault_pc=32'h22, no imem_req; later redirect_pc=32'h10 -> fault clears, fetch resumes at word 4.
- With IMEM_ADDR_W=8, redirect_pc=32'h400 -> fault. redirect_pc=32'h3FC -> fetches word 255; next pc 32'h400 faults.
- halt=1 from reset for 3 cycles -> imem_req=0 throughout; after halt falls, first fetch is at RESET_PC. Reset asserted in HOLD -> inst_valid=0 the next cycle.
